// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction decode stage with optional RV32M and Zicsr/mret decode.
// The raw instruction is decoded combinationally and captured, together with
// its pc, into a two-entry buffer (main + skid) on input transfer. The main
// entry is what downstream sees. The skid entry absorbs one instruction while
// main is stalled, so in_ready can come straight from a flop.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    upstream instruction valid
//   in_ready    stage can accept (registered, = !skid_full)
//   in_inst     raw 32-bit instruction
//   in_pc       instruction address (XLEN)
//   flush       drop both held entries and the incoming instruction
//   out_valid   main entry valid
//   out_ready   downstream accepts the main entry
//   out_inst    instruction of the main entry
//   out_pc      pc of the main entry
//   ctrl        26-bit decoded control bundle of the main entry
//
// ctrl map
//   [2:0] alu_op / M funct3   3 alu_imm   4 alu_sub   5 alu_sra   6 rd_w
//   7 ld_upper   8 add_pc   9 jmp_reg   10 is_branch   11 is_jmp
//   12 is_load   13 is_store   14 is_fence   15 is_fencei   16 is_csr
//   17 is_mret   18 exc_ecall   19 exc_break   20 csr_zimm   21 csr_w
//   22 csr_set   23 csr_clr   24 is_muldiv   25 exc_illegal
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int ENABLE_M   = 1,
    parameter int ENABLE_CSR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [25:0]     ctrl
);

    // ctrl bit positions
    localparam int B_ALU_IMM  = 3;
    localparam int B_ALU_SUB  = 4;
    localparam int B_ALU_SRA  = 5;
    localparam int B_RD_W     = 6;
    localparam int B_LD_UPPER = 7;
    localparam int B_ADD_PC   = 8;
    localparam int B_JMP_REG  = 9;
    localparam int B_BRANCH   = 10;
    localparam int B_JMP      = 11;
    localparam int B_LOAD     = 12;
    localparam int B_STORE    = 13;
    localparam int B_FENCE    = 14;
    localparam int B_FENCEI   = 15;
    localparam int B_CSR      = 16;
    localparam int B_MRET     = 17;
    localparam int B_ECALL    = 18;
    localparam int B_EBREAK   = 19;
    localparam int B_CSR_ZIMM = 20;
    localparam int B_CSR_W    = 21;
    localparam int B_CSR_SET  = 22;
    localparam int B_CSR_CLR  = 23;
    localparam int B_MULDIV   = 24;
    localparam int B_ILLEGAL  = 25;

    // Full 7-bit opcodes: a compressed encoding (inst[1:0] != 11) can never
    // match any of these, so it lands in the illegal default.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam bit M_ON   = (ENABLE_M != 0);
    localparam bit CSR_ON = (ENABLE_CSR != 0);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [25:0]     ctrl;
    } entry_t;

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // -------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [25:0] dec_raw;
    logic [25:0] dec_ctrl;
    logic        illegal;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    always_comb begin
        dec_raw = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_raw[B_RD_W]     = 1'b1;
                dec_raw[B_LD_UPPER] = 1'b1;
            end
            OPC_AUIPC: begin
                dec_raw[B_RD_W]   = 1'b1;
                dec_raw[B_ADD_PC] = 1'b1;
            end
            OPC_JAL: begin
                dec_raw[B_RD_W] = 1'b1;
                dec_raw[B_JMP]  = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    dec_raw[B_RD_W]    = 1'b1;
                    dec_raw[B_JMP]     = 1'b1;
                    dec_raw[B_JMP_REG] = 1'b1;
                    dec_raw[B_ALU_IMM] = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                if (funct3[2:1] == 2'b01) illegal = 1'b1;
                else                      dec_raw[B_BRANCH] = 1'b1;
            end
            OPC_LOAD: begin
                // lb lh lw lbu lhu
                if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
                    illegal = 1'b1;
                end else begin
                    dec_raw[B_RD_W]    = 1'b1;
                    dec_raw[B_ALU_IMM] = 1'b1;
                    dec_raw[B_LOAD]    = 1'b1;
                end
            end
            OPC_STORE: begin
                // sb sh sw
                if (funct3[2] || funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    dec_raw[B_ALU_IMM] = 1'b1;
                    dec_raw[B_STORE]   = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_raw[B_RD_W]    = 1'b1;
                dec_raw[B_ALU_IMM] = 1'b1;
                dec_raw[2:0]       = funct3;
                // Only the shift forms constrain the upper immediate bits.
                if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec_raw[B_ALU_SRA] = 1'b1;
                    else if (funct7 != F7_BASE) illegal = 1'b1;
                end
            end
            OPC_OP: begin
                dec_raw[B_RD_W] = 1'b1;
                dec_raw[2:0]    = funct3;
                if (funct7 == F7_BASE) begin
                    // plain register-register ALU op
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec_raw[B_ALU_SUB] = 1'b1;
                    else if (funct3 == 3'b101) dec_raw[B_ALU_SRA] = 1'b1;
                    else                       illegal = 1'b1;
                end else if (funct7 == F7_MUL && M_ON) begin
                    dec_raw[B_MULDIV] = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                if (funct3 == 3'b000)      dec_raw[B_FENCE]  = 1'b1;
                else if (funct3 == 3'b001) dec_raw[B_FENCEI] = 1'b1;
                else                       illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                case (funct3)
                    3'b000: begin
                        // privileged forms are matched on the whole word
                        if (in_inst == INST_ECALL)               dec_raw[B_ECALL]  = 1'b1;
                        else if (in_inst == INST_EBREAK)         dec_raw[B_EBREAK] = 1'b1;
                        else if (in_inst == INST_MRET && CSR_ON) dec_raw[B_MRET]   = 1'b1;
                        else                                     illegal = 1'b1;
                    end
                    3'b100: illegal = 1'b1;
                    default: begin
                        if (CSR_ON) begin
                            dec_raw[B_RD_W]     = 1'b1;
                            dec_raw[B_CSR]      = 1'b1;
                            dec_raw[B_CSR_ZIMM] = funct3[2];
                            case (funct3[1:0])
                                2'b01:   dec_raw[B_CSR_W]   = 1'b1;
                                2'b10:   dec_raw[B_CSR_SET] = 1'b1;
                                2'b11:   dec_raw[B_CSR_CLR] = 1'b1;
                                default: illegal = 1'b1;
                            endcase
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    // An illegal instruction still flows down the pipe, carrying only the
    // exception flag so nothing downstream acts on stale partial decode.
    always_comb begin
        dec_ctrl = dec_raw;
        if (illegal) begin
            dec_ctrl            = '0;
            dec_ctrl[B_ILLEGAL] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Two-entry buffer
    // -------------------------------------------------------------------------
    entry_t main_q, skid_q, in_entry;
    logic   main_v, skid_v;
    logic   in_fire, out_fire;

    assign in_entry = '{inst: in_inst, pc: in_pc, ctrl: dec_ctrl};

    // Skid is only ever filled while main is full, so !skid_v is exactly
    // "room for one more" and comes straight from a flop.
    assign in_ready = ~skid_v;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || out_fire) begin
            // main is free this edge: older skid entry wins, else take input
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (in_fire) begin
                main_q <= in_entry;
                main_v <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (in_fire) begin
            // main stalled: park the new instruction in skid
            skid_q <= in_entry;
            skid_v <= 1'b1;
        end
    end

    assign out_valid = main_v;
    assign out_inst  = main_q.inst;
    assign out_pc    = main_q.pc;
    assign ctrl      = main_q.ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Three decode_stage instances (default, ENABLE_M=0, ENABLE_CSR=0) share the
// same stimulus. A scoreboard queue records each accepted instruction with its
// expected ctrl for all three configurations; a monitor pops and compares on
// every output transfer. Hand-written sequences cover backpressure, flush and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam logic [25:0] ILL = 26'h200_0000;

    typedef struct {
        logic [31:0] inst;
        logic [25:0] c_def;
        logic [25:0] c_nom;
        logic [25:0] c_nocsr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [25:0] c_def;
        logic [25:0] c_nom;
        logic [25:0] c_nocsr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            fixed_ready;
    logic            rnd_ready = 1'b1;
    logic            rand_mode;
    logic            out_ready;

    logic            in_ready0, in_ready1, in_ready2;
    logic            out_valid0, out_valid1, out_valid2;
    logic [31:0]     out_inst0, out_inst1, out_inst2;
    logic [XLEN-1:0] out_pc0, out_pc1, out_pc2;
    logic [25:0]     ctrl0, ctrl1, ctrl2;

    int   ncmp = 0;
    int   nfail = 0;
    exp_t sb[$];
    exp_t cur;
    exp_t mon_e;
    vec_t tbl[28];

    assign out_ready = rand_mode ? rnd_ready : fixed_ready;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1), .ENABLE_CSR(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_inst(out_inst0),
        .out_pc(out_pc0), .ctrl(ctrl0)
    );

    decode_stage #(.XLEN(XLEN), .ENABLE_M(0), .ENABLE_CSR(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_inst(out_inst1),
        .out_pc(out_pc1), .ctrl(ctrl1)
    );

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1), .ENABLE_CSR(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
        .out_pc(out_pc2), .ctrl(ctrl2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // random backpressure source
    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 1) == 1);
    end

    // scoreboard: push on input transfer, pop/compare on output transfer
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_inst0, 32'hDEAD_BEEF);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_inst", out_inst0, mon_e.inst);
                    check("out_pc", out_pc0, mon_e.pc);
                    check("ctrl", 32'(ctrl0), 32'(mon_e.c_def));
                    check("ctrl_no_m", 32'(ctrl1), 32'(mon_e.c_nom));
                    check("ctrl_no_csr", 32'(ctrl2), 32'(mon_e.c_nocsr));
                end
            end
            if (in_valid && in_ready0) sb.push_back(cur);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic [31:0] pc);
        in_valid    = 1'b1;
        in_inst     = v.inst;
        in_pc       = pc;
        cur.inst    = v.inst;
        cur.pc      = pc;
        cur.c_def   = v.c_def;
        cur.c_nom   = v.c_nom;
        cur.c_nocsr = v.c_nocsr;
    endtask

    // hold the driven instruction until it is accepted (bounded)
    task automatic wait_accept();
        int n = 0;
        bit acc;
        do begin
            @(negedge clk);
            acc = in_ready0;
            step();
            n++;
        end while (!acc && n < 200);
        check("accept_in_time", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic [31:0] pc);
        drive(v, pc);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid0) && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
        fixed_ready = 1'b1; rand_mode = 1'b0;
        cur = '{inst: '0, pc: '0, c_def: '0, c_nom: '0, c_nocsr: '0};

        //                inst           default        no M           no CSR
        tbl[0]  = '{32'h00510093, 26'h0000048, 26'h0000048, 26'h0000048}; // addi
        tbl[1]  = '{32'h402081B3, 26'h0000050, 26'h0000050, 26'h0000050}; // sub
        tbl[2]  = '{32'h023100B3, 26'h1000040, ILL,         26'h1000040}; // mul
        tbl[3]  = '{32'h00000000, ILL,         ILL,         ILL};         // all zero
        tbl[4]  = '{32'h00000073, 26'h0040000, 26'h0040000, 26'h0040000}; // ecall
        tbl[5]  = '{32'h34001073, 26'h0210040, 26'h0210040, ILL};         // csrrw
        tbl[6]  = '{32'h00100073, 26'h0080000, 26'h0080000, 26'h0080000}; // ebreak
        tbl[7]  = '{32'h30200073, 26'h0020000, 26'h0020000, ILL};         // mret
        tbl[8]  = '{32'h123450B7, 26'h00000C0, 26'h00000C0, 26'h00000C0}; // lui
        tbl[9]  = '{32'h00001097, 26'h0000140, 26'h0000140, 26'h0000140}; // auipc
        tbl[10] = '{32'h008000EF, 26'h0000840, 26'h0000840, 26'h0000840}; // jal
        tbl[11] = '{32'h000080E7, 26'h0000A48, 26'h0000A48, 26'h0000A48}; // jalr
        tbl[12] = '{32'h00208463, 26'h0000400, 26'h0000400, 26'h0000400}; // beq
        tbl[13] = '{32'h0000A103, 26'h0001048, 26'h0001048, 26'h0001048}; // lw
        tbl[14] = '{32'h0020A223, 26'h0002008, 26'h0002008, 26'h0002008}; // sw
        tbl[15] = '{32'h40115093, 26'h000006D, 26'h000006D, 26'h000006D}; // srai
        tbl[16] = '{32'h4020D0B3, 26'h0000065, 26'h0000065, 26'h0000065}; // sra
        tbl[17] = '{32'h0FF0000F, 26'h0004000, 26'h0004000, 26'h0004000}; // fence
        tbl[18] = '{32'h0000100F, 26'h0008000, 26'h0008000, 26'h0008000}; // fence.i
        tbl[19] = '{32'h3400E073, 26'h0510040, 26'h0510040, ILL};         // csrrsi
        tbl[20] = '{32'h00004073, ILL,         ILL,         ILL};         // SYSTEM f3=100
        tbl[21] = '{32'h080000B3, ILL,         ILL,         ILL};         // OP bad funct7
        tbl[22] = '{32'h40109093, ILL,         ILL,         ILL};         // slli bad funct7
        tbl[23] = '{32'h00000001, ILL,         ILL,         ILL};         // inst[1:0]=01
        tbl[24] = '{32'h0220D0B3, 26'h1000045, ILL,         26'h1000045}; // divu
        tbl[25] = '{32'h0FF14093, 26'h000004C, 26'h000004C, 26'h000004C}; // xori
        tbl[26] = '{32'h0000B103, ILL,         ILL,         ILL};         // load f3=011
        tbl[27] = '{32'h34003073, 26'h0810040, 26'h0810040, ILL};         // csrrc

        // reset state
        #3;
        check("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready0}, 32'd1);
        check("rst_ctrl", 32'(ctrl0), 32'd0);
        check("rst_out_pc", out_pc0, 32'd0);
        check("rst_out_inst", out_inst0, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();

        // full-throughput stream of the whole table
        foreach (tbl[i]) send(tbl[i], 32'h1000 + 32'(i) * 4);
        drain();

        // backpressure: third instruction must wait upstream
        fixed_ready = 1'b0;
        drive(tbl[0], 32'h2000);
        @(negedge clk); check("bp_ready_0", {31'b0, in_ready0}, 32'd1);
        step();
        drive(tbl[1], 32'h2004);
        @(negedge clk); check("bp_ready_1", {31'b0, in_ready0}, 32'd1);
        check("bp_out_valid", {31'b0, out_valid0}, 32'd1);
        step();
        drive(tbl[2], 32'h2008);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_full", {31'b0, in_ready0}, 32'd0);
            check("bp_hold_inst", out_inst0, tbl[0].inst);
            check("bp_hold_pc", out_pc0, 32'h2000);
            check("bp_hold_ctrl", 32'(ctrl0), 32'(tbl[0].c_def));
            step();
        end
        fixed_ready = 1'b1;
        wait_accept();
        drain();

        // flush with both entries full and a new input presented
        fixed_ready = 1'b0;
        send(tbl[3], 32'h3000);
        send(tbl[4], 32'h3004);
        @(negedge clk); check("fl_pre_ready", {31'b0, in_ready0}, 32'd0);
        step();
        drive(tbl[5], 32'h3008);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {31'b0, out_valid0}, 32'd0);
        check("fl_in_ready", {31'b0, in_ready0}, 32'd1);
        check("fl_out_valid_nocsr", {31'b0, out_valid2}, 32'd0);
        fixed_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fl_stays_empty", {31'b0, out_valid0}, 32'd0);
            step();
        end

        // asynchronous reset mid-stream
        send(tbl[8], 32'h4000);
        send(tbl[9], 32'h4004);
        drive(tbl[10], 32'h4008);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, out_valid0}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready0}, 32'd1);
        check("arst_ctrl", 32'(ctrl0), 32'd0);
        check("arst_out_pc", out_pc0, 32'd0);
        check("arst_out_inst", out_inst0, 32'd0);
        in_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_output", {31'b0, out_valid0}, 32'd0);
            step();
        end
        send(tbl[0], 32'h5000);
        drain();

        // whole table again under random backpressure
        rand_mode = 1'b1;
        foreach (tbl[i]) send(tbl[i], 32'h6000 + 32'(i) * 4);
        drain();
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
